// File: rtl/toggle_pkg.sv
// Shared types and default widths for the toggle monitor.
package toggle_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOST    = 2'd2
    } state_e;

    localparam int DEF_W    = 32;
    localparam int DEF_EC_W = 16;

endpackage

// File: rtl/toggle_monitor_edge_sync.sv
// Two-flop synchroniser plus history flop for one asynchronous input pin.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic in_pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = in_pin;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~s3_q;
    assign fall  = ~s2_q & s3_q;

endmodule

// File: rtl/toggle_monitor.sv
// Measures period and high time of an asynchronous square wave and flags loss of signal.
// Optional build macro PERIOD_CHECK_EN enables the period_err tolerance check.
module toggle_monitor
    import toggle_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int TIMEOUT    = 100000,
    parameter int EC_W       = DEF_EC_W,
    parameter int EXP_PERIOD = 24002,
    parameter int TOL        = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_pin,
    output logic [W-1:0]    period_out,
    output logic [W-1:0]    high_out,
    output logic            meas_valid,
    output logic            timeout,
    output logic [EC_W-1:0] edge_count,
    output logic            period_err
);

    localparam logic [W-1:0] TO_C = W'(TIMEOUT);

    logic level, rise, fall;

    edge_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .in_pin (in_pin),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    state_e          state_q, state_d;
    logic [W-1:0]    period_cnt_q, period_cnt_d;
    logic [W-1:0]    high_cnt_q, high_cnt_d;
    logic [W-1:0]    high_lat_q, high_lat_d;
    logic [W-1:0]    period_out_q, period_out_d;
    logic [W-1:0]    high_out_q, high_out_d;
    logic            meas_valid_q, meas_valid_d;
    logic            timeout_q, timeout_d;
    logic [EC_W-1:0] edge_cnt_q, edge_cnt_d;
    logic            period_err_q, period_err_d;
    logic            period_bad;
    logic            at_limit;

    assign at_limit = (period_cnt_q == TO_C);

`ifdef PERIOD_CHECK_EN
    localparam logic [W:0] EXP_C = (W+1)'(EXP_PERIOD);
    localparam logic [W:0] TOL_C = (W+1)'(TOL);
    logic [W:0] diff;

    // Judged on the count being latched, so the flag lines up with meas_valid.
    always_comb begin
        if ({1'b0, period_cnt_q} >= EXP_C) diff = {1'b0, period_cnt_q} - EXP_C;
        else                               diff = EXP_C - {1'b0, period_cnt_q};
        period_bad = (diff > TOL_C);
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{EXP_PERIOD, TOL};
    assign period_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            high_lat_q   <= '0;
            period_out_q <= '0;
            high_out_q   <= '0;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            edge_cnt_q   <= '0;
            period_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            high_lat_q   <= high_lat_d;
            period_out_q <= period_out_d;
            high_out_q   <= high_out_d;
            meas_valid_q <= meas_valid_d;
            timeout_q    <= timeout_d;
            edge_cnt_q   <= edge_cnt_d;
            period_err_q <= period_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise) state_d = MEASURE;
            MEASURE: if (!rise && at_limit) state_d = LOST;
            LOST:    if (rise) state_d = MEASURE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        high_lat_d   = high_lat_q;
        period_out_d = period_out_q;
        high_out_d   = high_out_q;
        meas_valid_d = 1'b0;
        timeout_d    = timeout_q;
        edge_cnt_d   = edge_cnt_q;
        period_err_d = 1'b0;
        case (state_q)
            IDLE, LOST: begin
                // No trustworthy previous edge, so a rise only restarts counting.
                if (rise) begin
                    period_cnt_d = W'(1);
                    high_cnt_d   = W'(1);
                    edge_cnt_d   = edge_cnt_q + EC_W'(1);
                    timeout_d    = 1'b0;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_out_d = period_cnt_q;
                    high_out_d   = high_lat_q;
                    meas_valid_d = 1'b1;
                    period_err_d = period_bad;
                    period_cnt_d = W'(1);
                    high_cnt_d   = W'(1);
                    edge_cnt_d   = edge_cnt_q + EC_W'(1);
                end else if (at_limit) begin
                    timeout_d = 1'b1;
                end else begin
                    period_cnt_d = period_cnt_q + W'(1);
                    if (level) high_cnt_d = high_cnt_q + W'(1);
                    if (fall)  high_lat_d = high_cnt_q;
                end
            end
            default: ;
        endcase
    end

    assign period_out = period_out_q;
    assign high_out   = high_out_q;
    assign meas_valid = meas_valid_q;
    assign timeout    = timeout_q;
    assign edge_count = edge_cnt_q;
    assign period_err = period_err_q;

endmodule

// File: tb/tb_toggle_monitor.sv
// Directed bench for toggle_monitor with a measurement scoreboard.
module tb_toggle_monitor;

    localparam int W    = 32;
    localparam int TO   = 500;
    localparam int ECW  = 16;
    localparam int EXP  = 200;
    localparam int TOLV = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_pin;
    logic [W-1:0]   period_out, high_out;
    logic           meas_valid, timeout, period_err;
    logic [ECW-1:0] edge_count;

    toggle_monitor #(.W(W), .TIMEOUT(TO), .EC_W(ECW), .EXP_PERIOD(EXP), .TOL(TOLV)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_pin     (in_pin),
        .period_out (period_out),
        .high_out   (high_out),
        .meas_valid (meas_valid),
        .timeout    (timeout),
        .edge_count (edge_count),
        .period_err (period_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] p;
        logic [W-1:0] h;
        logic         e;
    } exp_t;

    exp_t         sb[$];
    exp_t         got;
    int           n_tests = 0;
    int           n_fail  = 0;
    int           rises   = 0;
    logic [W-1:0] hold_p  = '0;
    logic [W-1:0] hold_h  = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic exp_err(input int p);
`ifdef PERIOD_CHECK_EN
        int d;
        d = (p > EXP) ? p - EXP : EXP - p;
        return d > TOLV;
`else
        return 1'b0;
`endif
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int p, input int h);
        exp_t e;
        e.p = W'(p);
        e.h = W'(h);
        e.e = exp_err(p);
        sb.push_back(e);
    endtask

    // v: this rise closes a valid period (ep/eh describe that closed period)
    task automatic pulse(input int h, input int l, input bit v, input int ep, input int eh);
        if (v) push(ep, eh);
        in_pin = 1'b1;
        rises++;
        cyc(h);
        in_pin = 1'b0;
        cyc(l);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (meas_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_meas_valid", 1, 0);
                end else begin
                    got = sb.pop_front();
                    chk("period_out", period_out, got.p);
                    chk("high_out", high_out, got.h);
                    chk("period_err_on_meas", period_err, got.e);
                    hold_p = got.p;
                    hold_h = got.h;
                end
            end else begin
                chk("period_out_hold", period_out, hold_p);
                chk("high_out_hold", high_out, hold_h);
                chk("period_err_idle", period_err, 0);
            end
        end
    end

    logic [ECW-1:0] ec0;
    int             k_rise, k_to, kk;
    logic           prev_to;

    initial begin
        rst    = 1'b1;
        in_pin = 1'b0;
        cyc(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_period_out", period_out, 0);
        chk("rst_high_out", high_out, 0);
        chk("rst_meas_valid", meas_valid, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_edge_count", edge_count, 0);
        chk("rst_period_err", period_err, 0);

        // 50% duty, first rise after reset yields nothing
        pulse(120, 120, 0, 0, 0);
        repeat (3) pulse(120, 120, 1, 240, 120);
        @(negedge clk);
        chk("edge_count_50pct", edge_count, ECW'(rises));

        // 30/70 duty
        pulse(60, 140, 1, 240, 120);
        pulse(60, 140, 1, 200, 60);
        pulse(60, 140, 1, 200, 60);

        // periods around EXP: 202 within tolerance, 203 and 197 outside
        pulse(100, 102, 1, 200, 60);
        pulse(100, 103, 1, 202, 100);
        pulse(50, 147, 1, 203, 100);
        pulse(60, 140, 1, 197, 50);
        @(negedge clk);
        chk("edge_count_duty", edge_count, ECW'(rises));

        // period exactly TIMEOUT: rise wins, normal measurement
        pulse(200, 300, 1, 200, 60);
        pulse(60, 140, 1, 500, 200);
        @(negedge clk);
        chk("timeout_boundary_stays_low", timeout, 0);

        // stop toggling after one more rise
        push(200, 60);
        ec0    = edge_count;
        in_pin = 1'b1;
        rises++;
        k_rise = -1;
        k_to   = -1;
        for (int k = 1; k <= 1200; k++) begin
            cyc(1);
            if (k == 60) in_pin = 1'b0;
            @(negedge clk);
            if (k_rise < 0 && edge_count != ec0) k_rise = k;
            if (timeout) begin
                k_to = k;
                break;
            end
        end
        chk("timeout_seen", k_to > 0, 1);
        chk("timeout_latency", k_to - k_rise, TO);
        cyc(20);
        @(negedge clk);
        chk("timeout_held", timeout, 1);
        chk("edge_count_lost", edge_count, ECW'(rises));

        // resume: timeout clears with the detected rise, no measurement
        ec0     = edge_count;
        prev_to = timeout;
        in_pin  = 1'b1;
        rises++;
        kk = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            @(negedge clk);
            if (edge_count != ec0) begin
                kk = k;
                break;
            end
            prev_to = timeout;
        end
        chk("resume_detected", kk > 0, 1);
        chk("timeout_cleared", timeout, 0);
        chk("timeout_set_before_rise", prev_to, 1);
        cyc(60 - kk);
        in_pin = 1'b0;
        cyc(140);
        pulse(60, 140, 1, 200, 60);
        @(negedge clk);
        chk("edge_count_resume", edge_count, ECW'(rises));

        // reset mid-period
        push(200, 60);
        in_pin = 1'b1;
        rises++;
        cyc(60);
        in_pin = 1'b0;
        cyc(50);
        rst    = 1'b1;
        hold_p = '0;
        hold_h = '0;
        cyc(1);
        rst   = 1'b0;
        rises = 0;
        @(negedge clk);
        chk("mid_rst_period_out", period_out, 0);
        chk("mid_rst_high_out", high_out, 0);
        chk("mid_rst_meas_valid", meas_valid, 0);
        chk("mid_rst_timeout", timeout, 0);
        chk("mid_rst_edge_count", edge_count, 0);
        chk("mid_rst_period_err", period_err, 0);
        chk("sb_drained_before_rst", sb.size(), 0);
        cyc(90);
        pulse(60, 140, 0, 0, 0);
        pulse(70, 130, 1, 200, 60);
        push(200, 70);
        in_pin = 1'b1;
        rises++;
        cyc(20);
        @(negedge clk);
        chk("sb_drained_end", sb.size(), 0);
        chk("edge_count_after_rst", edge_count, ECW'(rises));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/toggle_monitor.md
Name: toggle_monitor

Overview:
Receive-side counterpart of the counter-driven toggle generators. It samples one asynchronous square-wave input pin and measures its period and high time in system-clock cycles. It publishes each completed measurement with a one-cycle valid strobe and flags loss of signal. It sits on the board-level loopback or probe path, where it checks generated pulse trains on hardware without a scope.

Parameters:
W, 32, width of period/high-time counters and outputs
TIMEOUT, 100000, cycles without a rising edge before loss-of-signal; legal range 2..2^W-2
EC_W, 16, width of rising-edge counter
EXP_PERIOD, 24002, expected period in cycles (used only with PERIOD_CHECK_EN)
TOL, 2, allowed |period - EXP_PERIOD| (used only with PERIOD_CHECK_EN)

Ports:
clk  input  1  system clock; the only clock
rst  input  1  synchronous, active-high reset
in_pin  input  1  asynchronous square-wave input
period_out  output  W  cycles between last two rising edges
high_out  output  W  cycles input was high within that period
meas_valid  output  1  one-cycle strobe; period_out/high_out updated this cycle
timeout  output  1  level; no rising edge for TIMEOUT cycles
edge_count  output  EC_W  rising edges seen since reset, wraps
period_err  output  1  period check failure (see Optional Feature)

Behaviour:
- Interface decision: single clock clk; rst is synchronous and active-high.
- Reset: period_out=0, high_out=0, meas_valid=0, timeout=0, edge_count=0, period_err=0. Synchroniser flops=0. Counters=0. State=IDLE. Reset mid-measurement discards the partial count. The first edge after reset is handled as from IDLE.
- Sync/edge: in_pin passes through 2 flops (s1,s2) and then a history flop s3. rise=s2&~s3, fall=~s2&s3. An edge is detected 2 clk after the clk edge that first samples the new level.
- States: IDLE (awaiting first rise), MEASURE, LOST.
- IDLE: on rise -> MEASURE, period_cnt<=1, high_cnt<=1, edge_count+1. No meas_valid.
- MEASURE, each cycle without rise: period_cnt+1. high_cnt+1 while s2=1.
- MEASURE, on fall: high_lat<=high_cnt.
- MEASURE, on rise: period_out<=period_cnt, high_out<=high_lat. meas_valid=1 on the next cycle, coincident with the updated outputs. period_cnt<=1, high_cnt<=1, edge_count+1 (wrap at 2^EC_W).
- MEASURE: when period_cnt==TIMEOUT and there is no rise -> LOST, timeout<=1. Rise in that same cycle takes priority and produces a normal measurement.
- LOST: counters hold. On rise -> MEASURE, timeout<=0 next cycle, period_cnt<=1, edge_count+1, no meas_valid because the interval is invalid.
- Pulse shorter than 1 cycle after synchronisation may vanish; no requirement. A 1-cycle high gives high_out=1.
- Outputs hold their last values between strobes. Counters never exceed TIMEOUT, so no saturation logic is required.

Optional Feature:
- Macro: PERIOD_CHECK_EN.
- Defined: on each meas_valid, period_err=1 for that cycle if |period_out-EXP_PERIOD|>TOL, else 0. The absolute difference is computed in W+1 bits.
- Not defined: period_err is tied 0; EXP_PERIOD and TOL are unused. The port list is identical in both builds.

Decomposition:
- Package toggle_pkg: state enum (IDLE, MEASURE, LOST) and default W/EC_W constants.
- One sub-module, edge_sync: 2-flop synchroniser plus history flop, producing level, rise and fall, with synchronous active-high reset.
- All counting and the FSM live in toggle_monitor.

Test Plan:
- Toggle in_pin every 12001 clk (50% duty) -> after 2nd rise, meas_valid pulses once per 24002 clk, period_out=24002, high_out=12001, edge_count increments by 1 per rise.
- Duty 30/70: high 300, low 700 clk -> period_out=1000, high_out=300. First rise after reset gives no meas_valid.
- TIMEOUT=500, stop toggling -> timeout=1 exactly 500 clk after the last detected rise. Resume -> timeout=0 one cycle after the next detected rise; meas_valid only from the following rise onward.
- Rise landing on the cycle period_cnt==TIMEOUT -> meas_valid with period_out=TIMEOUT, timeout stays 0.
- Assert rst for 1 clk mid-period -> all outputs 0 next cycle, state IDLE. The next rise produces no meas_valid; the second rise produces a correct period.
- With PERIOD_CHECK_EN, EXP_PERIOD=1000, TOL=2: periods 1002 -> period_err=0, 1003 -> period_err=1 with meas_valid. Without the macro -> period_err always 0.
